alu_mc: RTL

Parametrised multi-cycle ALU for the execute stage of the next-generation core. It extends the four-op combinational ALU with a wider op set, a full flag set and an iterative multiply/divide unit. Operands pass through a valid/ready handshake on both sides, so the datapath can stall on long ops. Single-cycle ops return one cycle after acceptance; mul/div ops return after WIDTH iteration cycles.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_muldiv_seq.sv | 78 +++++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state encoding
// and small helpers used by the top level and the mul/div sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of low-order b bits that form a shift amount.
    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// 2*WIDTH accumulator; one iteration per cycle, WIDTH iterations per op.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         op_reg;
    logic [CW-1:0]      cnt_reg;
    logic               running_reg, done_reg;
    logic               is_div;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_diff;

    assign is_div = (op_reg == ALU_DIVU) || (op_reg == ALU_REMU);

    // Multiply: {hi,lo} starts as {0,a}; add b into hi when lo[0] is set, shift right.
    // Divide:   {rem,quo} starts as {0,a}; shift left, subtract b from rem when it fits.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   (acc_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        rem_diff = WIDTH'(rem_sh - {1'b0, b_reg});
        acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, b_reg})
                acc_next = {rem_diff, acc_reg[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else if (start) begin
            acc_reg     <= {{WIDTH{1'b0}}, a};
            b_reg       <= b;
            op_reg      <= op;
            cnt_reg     <= CW'(WIDTH - 1);
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
        end else if (running_reg) begin
            acc_reg <= acc_next;
            if (cnt_reg == '0) begin
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign done   = done_reg;
    assign result = ((op_reg == ALU_MUL) || (op_reg == ALU_DIVU)) ?
                    acc_reg[WIDTH-1:0] : acc_reg[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops complete one
// cycle after accept, mul/div ops are delegated to alu_muldiv_seq.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    import alu_pkg::*;

    localparam int SW = shamt_width(WIDTH);

    state_t           state_reg, state_next;
    logic             pending_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             accept, md_start, md_done, load_sc, load_md;
    logic [WIDTH-1:0] md_result, sc_result;
    logic             sc_carry, sc_ovf, sc_illegal;
    logic [WIDTH:0]   sum;

    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_muldiv(ALUControl);
    assign load_sc  = (state_reg == IDLE) && pending_reg && !is_muldiv(op_reg);
    assign load_md  = (state_reg == BUSY) && md_done;

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (ALUControl),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // pending_reg marks the cycle between accept and the op being dispatched.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pending_reg) state_next = is_muldiv(op_reg) ? BUSY : DONE;
            BUSY:    if (md_done)     state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) && !pending_reg;
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
        end else begin
            pending_reg <= accept;
            if (accept) begin
                op_reg <= ALUControl;
                a_reg  <= a;
                b_reg  <= b;
            end
        end
    end

    always_comb begin
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        sum        = '0;
        case (op_reg)
            ALU_ADD: begin
                sum       = {1'b0, a_reg} + {1'b0, b_reg};
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
                sc_ovf    = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            ALU_SUB: begin
                sum       = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
                sc_ovf    = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            ALU_AND:  sc_result = a_reg & b_reg;
            ALU_OR:   sc_result = a_reg | b_reg;
            ALU_XOR:  sc_result = a_reg ^ b_reg;
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a_reg < b_reg)};
            ALU_SLL:  sc_result = a_reg << b_reg[SW-1:0];
            ALU_SRL:  sc_result = a_reg >> b_reg[SW-1:0];
            ALU_SRA:  sc_result = $signed(a_reg) >>> b_reg[SW-1:0];
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: sc_illegal = 1'b0;
            default:  sc_illegal = 1'b1;
        endcase
    end

    // Result and flags only change when a new result is produced, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_sc) begin
            ALUResult <= sc_result;
            zero      <= (sc_result == '0);
            negative  <= sc_result[WIDTH-1];
            carry     <= sc_carry;
            overflow  <= sc_ovf;
            illegal   <= sc_illegal;
        end else if (load_md) begin
            ALUResult <= md_result;
            zero      <= (md_result == '0);
            negative  <= md_result[WIDTH-1];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end
    end

endmodule
